// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 5208;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detect
// on the synchronized value; all flops preset to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 only remembers the previous synchronized level for edge detection
  assign rx_s    = s2;
  assign rx_fall = s3 & ~s2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), sampling at mid-bit.
// The FSM state is exposed on dbg_state.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       parity_err,
  output rx_state_e  dbg_state
);

  // Handshake: rdy is the valid flag for rx_data; clr_rdy is the consumer's
  // acknowledge and clears rdy on the following cycle. A new start edge also
  // clears rdy, and a byte landing in the same cycle as clr_rdy keeps rdy high.

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_s;
  logic          rx_fall;
  rx_state_e     state;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          load_ok;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (RX),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_err_q;
  assign load_ok    = ~par_bad;
  assign parity_err = par_err_q;
`else
  assign load_ok    = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      frm_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
      if (clr_rdy) rdy <= 1'b0;

      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
          par_bad  <= 1'b0;
`endif
          if (rx_fall) begin
            state <= ST_START;
            rdy   <= 1'b0;
          end
        end

        ST_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt  <= '0;
            par_bad   <= (rx_s != ^shift);
            par_err_q <= (rx_s != ^shift);
            state     <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`endif

        ST_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
            if (!rx_s) begin
              frm_err <= 1'b1;
            end else if (load_ok) begin
              rx_data <= shift;
              rdy     <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
